// File: rtl/xor_frame_accum.sv
// rtl/xor_frame_accum.sv - streaming XOR frame accumulator with parity, beat count and overflow
//
// Purpose:
//   Folds a frame of WIDTH-bit words into a single bitwise-XOR word. It also
//   reports the XOR-reduction parity of that word, the number of beats in the
//   frame (saturating at MAX_WORDS), and a sticky flag for frames longer than
//   MAX_WORDS. Both sides use a valid/ready handshake.
//
// Optional feature (macro XOR_FRAME_CHECK_EN):
//   Adds in_exp, which is sampled on the in_last beat, and out_err, which is
//   set when the folded word differs from in_exp.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      source presents a word
//   in_ready      block accepts a word this cycle (registered, state-only)
//   in_data       word to fold
//   in_last       accepted word ends the frame
//   out_valid     result available (HOLD state)
//   out_ready     sink takes the result
//   out_word      XOR of all words in the frame
//   out_bit       XOR-reduction of out_word
//   out_count     beats in the frame, saturating at MAX_WORDS
//   out_overflow  frame had more than MAX_WORDS beats
//   in_exp        (XOR_FRAME_CHECK_EN) expected fold, sampled on the last beat
//   out_err       (XOR_FRAME_CHECK_EN) folded word != in_exp

module xor_frame_accum #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef XOR_FRAME_CHECK_EN
  input  logic [WIDTH-1:0] in_exp,
  output logic             out_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_bit,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;
  logic             par_q,   par_d;
  logic             rdy_q,   rdy_d;
  logic             accept;
`ifdef XOR_FRAME_CHECK_EN
  logic             err_q,   err_d;
`endif

  // in_ready is registered from the next state so it is 0 during reset,
  // rises on the first edge after release, and never depends on in_valid.
  assign accept = in_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef XOR_FRAME_CHECK_EN
    err_d   = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          cnt_d   = CNT_ONE;
          ovf_d   = 1'b0;
          state_d = in_last ? S_HOLD : S_ACC;
        end
      end

      S_ACC: begin
        if (accept) begin
          // Words past saturation still fold into the accumulator.
          acc_d = acc_q ^ in_data;
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (in_last) begin
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
`ifdef XOR_FRAME_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end

      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

`ifdef XOR_FRAME_CHECK_EN
    // The comparison uses the post-fold value, so the last word is included.
    if (accept && in_last && (state_q != S_HOLD)) begin
      err_d = (acc_d != in_exp);
    end
`endif

    // Parity is registered with the word so out_bit has no logic after the flop.
    par_d = ^acc_d;
    rdy_d = (state_d != S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      par_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      par_q   <= par_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef XOR_FRAME_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign out_err = err_q;
`endif

  assign in_ready     = rdy_q;
  assign out_valid    = (state_q == S_HOLD);
  assign out_word     = acc_q;
  assign out_bit      = par_q;
  assign out_count    = cnt_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_xor_frame_accum.sv
// tb/tb_xor_frame_accum.sv - scoreboard bench for xor_frame_accum (WIDTH=8, MAX_WORDS=4)

module tb_xor_frame_accum;

  localparam int W    = 8;
  localparam int MAXW = 4;
  localparam int CW   = $clog2(MAXW + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_word;
  logic          out_bit;
  logic [CW-1:0] out_count;
  logic          out_overflow;
`ifdef XOR_FRAME_CHECK_EN
  logic [W-1:0]  in_exp;
  logic          out_err;
`endif

  always #5 clk = ~clk;

  xor_frame_accum #(.WIDTH(W), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
`ifdef XOR_FRAME_CHECK_EN
    .in_exp       (in_exp),
    .out_err      (out_err),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .out_bit      (out_bit),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  typedef struct {
    logic [W-1:0]  word;
    logic          par;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          err;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the frame in progress.
  logic [W-1:0] m_acc;
  int           m_cnt;
  logic         m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [W-1:0] d, input logic last, input logic [W-1:0] expv);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
`ifdef XOR_FRAME_CHECK_EN
    in_exp   = expv;
`endif
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $error("FAIL in_ready_timeout: observed 0 expected 1");
    end else begin
      if (m_cnt == MAXW) m_ovf = 1'b1;
      m_acc = m_acc ^ d;
      if (m_cnt < MAXW) m_cnt++;
      if (last) begin
        e.word = m_acc;
        e.par  = ^m_acc;
        e.cnt  = CW'(m_cnt);
        e.ovf  = m_ovf;
        e.err  = (m_acc != expv);
        sb.push_back(e);
        model_clear();
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last beat; out_valid must already be high.
  task automatic expect_result(input string tag, input bit bp);
    int   n = 0;
    exp_t e;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 0);
    if (!out_valid || sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_out_valid_timeout: observed %0d expected 1", tag, out_valid);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_word"}, out_word, e.word);
    chk({tag, "_bit"},  out_bit,  e.par);
    chk({tag, "_cnt"},  out_count, e.cnt);
    chk({tag, "_ovf"},  out_overflow, e.ovf);
`ifdef XOR_FRAME_CHECK_EN
    chk({tag, "_err"},  out_err, e.err);
`endif
    if (bp) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hEE;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        chk({tag, "_bp_in_ready"},  in_ready, 1'b0);
        chk({tag, "_bp_out_valid"}, out_valid, 1'b1);
        chk({tag, "_bp_word"},      out_word, e.word);
        chk({tag, "_bp_cnt"},       out_count, e.cnt);
        chk({tag, "_bp_bit"},       out_bit, e.par);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_post_out_valid"}, out_valid, 1'b0);
    chk({tag, "_post_in_ready"},  in_ready, 1'b1);
    chk({tag, "_post_cnt"},       out_count, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
`ifdef XOR_FRAME_CHECK_EN
    in_exp    = '0;
`endif
    model_clear();

    #12;
    chk("rst_in_ready",  in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_word",      out_word, 0);
    chk("rst_bit",       out_bit, 1'b0);
    chk("rst_cnt",       out_count, 0);
    chk("rst_ovf",       out_overflow, 1'b0);
`ifdef XOR_FRAME_CHECK_EN
    chk("rst_err",       out_err, 1'b0);
`endif
    #10 rst_n = 1'b1;
    #1 chk("rel_in_ready_before_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Basic frame: A5 ^ 3C ^ FF = 66, even parity.
    send_beat(8'hA5, 1'b0, 8'h00);
    send_beat(8'h3C, 1'b0, 8'h00);
    send_beat(8'hFF, 1'b1, 8'h66);
    chk("basic_word_const", out_word, 8'h66);
    chk("basic_cnt_const",  out_count, 3);
    expect_result("basic", 1'b0);

    // Single-word frame followed by backpressure.
    send_beat(8'h01, 1'b1, 8'h01);
    chk("single_bit_const", out_bit, 1'b1);
    expect_result("single_bp", 1'b1);

    // Overflow: six beats with MAX_WORDS=4.
    for (int i = 0; i < 6; i++) send_beat(8'h01, (i == 5), 8'h00);
    chk("ovf_word_const", out_word, 8'h00);
    chk("ovf_flag_const", out_overflow, 1'b1);
    expect_result("ovf", 1'b0);

    // Following frame must report no overflow.
    send_beat(8'h80, 1'b0, 8'h00);
    send_beat(8'h01, 1'b1, 8'h81);
    chk("after_ovf_flag", out_overflow, 1'b0);
    expect_result("after_ovf", 1'b0);

    // Exactly MAX_WORDS beats: saturates without overflow.
    for (int i = 0; i < MAXW; i++) send_beat(8'h10 << i, (i == MAXW - 1), 8'hF0);
    expect_result("exact_max", 1'b0);

    // Asynchronous reset mid-frame.
    send_beat(8'h0F, 1'b0, 8'h00);
    send_beat(8'h03, 1'b0, 8'h00);
    chk("mid_word_before_rst", out_word, 8'h0C);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_word",      out_word, 0);
    chk("mid_rst_cnt",       out_count, 0);
    chk("mid_rst_in_ready",  in_ready, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    #2 rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    chk("mid_rel_in_ready", in_ready, 1'b1);
    send_beat(8'h55, 1'b1, 8'h55);
    expect_result("after_rst", 1'b0);

`ifdef XOR_FRAME_CHECK_EN
    send_beat(8'h12, 1'b0, 8'h00);
    send_beat(8'h34, 1'b1, 8'h26);
    chk("chk_match_const", out_err, 1'b0);
    expect_result("chk_match", 1'b0);
    send_beat(8'h12, 1'b0, 8'h00);
    send_beat(8'h34, 1'b1, 8'h27);
    chk("chk_miss_const", out_err, 1'b1);
    expect_result("chk_miss", 1'b0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xor_frame_accum.md
# xor_frame_accum

Parametrised streaming XOR accumulator. It folds a frame of WIDTH-bit words into one bitwise-XOR word, plus a single reduction-parity bit. It uses a valid/ready handshake on both sides, which makes it the registered, multi-word successor to the team's 2-input XOR gate. It sits between a word source and any integrity or parity consumer, and can be chained behind any block with a valid/ready output.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- MAX_WORDS, 16, frame length at which the beat counter saturates (≥1); CW = $clog2(MAX_WORDS+1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  source has a word
- in_ready  output  1  block accepts a word this cycle
- in_data  input  WIDTH  word to fold
- in_last  input  1  the accepted word ends the frame
- out_valid  output  1  result available
- out_ready  input  1  sink takes the result
- out_word  output  WIDTH  XOR of all words in the frame
- out_bit  output  1  XOR-reduction of out_word
- out_count  output  CW  number of beats in the frame, saturating at MAX_WORDS
- out_overflow  output  1  the frame had more than MAX_WORDS beats

## Operation
- The block has one clock, clk, and an asynchronous active-low reset, rst_n.
- The state machine has three states: IDLE, ACC and HOLD.
- IDLE: the accumulator and count are zero, and in_ready=1.
  - An accepted beat (in_valid && in_ready) with in_last=0 sets acc=in_data and count=1, then moves to ACC.
  - An accepted beat with in_last=1 moves straight to HOLD with the result acc=in_data and count=1.
- ACC: in_ready=1.
  - Each accepted beat does acc ^= in_data.
  - count increments, saturating at MAX_WORDS.
  - overflow sets sticky when a beat arrives while count==MAX_WORDS.
  - A beat with in_last=1 performs its fold and then moves to HOLD.
  - Words past saturation are still folded into acc.
- HOLD: in_ready=0 and out_valid=1.
  - out_word, out_bit, out_count and out_overflow are registered and stay stable.
  - When out_valid && out_ready, the block clears acc, count and overflow and returns to IDLE.
- out_bit = ^out_word.
- Zero-length frames cannot occur, because every frame contains at least the beat that carries in_last.
- in_last is ignored on cycles with no handshake.
- Reset values: in_ready=0 while rst_n is low and 1 from the first cycle after release; out_valid=0, out_word=0, out_bit=0, out_count=0, out_overflow=0; state=IDLE.
- An asserted rst_n aborts any frame in progress or any held result immediately. The partial frame is discarded and no result is emitted.

## Timing
- Latency: out_valid rises on the clock edge that accepts the in_last beat, so it is visible in the next cycle.
- Input throughput: one word per cycle while in ACC or IDLE.
- Between frames there is at least one cycle with in_ready=0 (HOLD) before the next frame can start.
- The earliest next-frame beat is the cycle after the output handshake. There is no same-cycle bypass from out_ready to in_ready.
- Back-to-back frames: with out_ready held high, frames repeat at a period of (N beats + 1 cycle).
- Output signals are unchanged while out_valid && !out_ready.
- in_ready is a pure function of state and does not depend on in_valid combinationally.

## Configuration
- Macro: XOR_FRAME_CHECK_EN.
- When defined, the block adds:
  - input in_exp[WIDTH], sampled on the in_last beat;
  - output out_err (1 bit), registered into HOLD as (final acc != in_exp), reset value 0, stable in HOLD and cleared on the output handshake.
- When undefined, in_exp and out_err do not exist and the behaviour of all other ports is identical.

## Test plan
- Basic frame, WIDTH=8: send 0xA5, 0x3C, 0xFF with in_last on the third word and out_ready=1. Required: one cycle later out_valid=1, out_word=0x66, out_bit=0, out_count=3, out_overflow=0.
- Single-word frame: send 0x01 with in_last=1. Required: out_word=0x01, out_bit=1, out_count=1.
- Backpressure: after a frame completes, hold out_ready=0 for 5 cycles while in_valid=1. Required: in_ready=0 and all outputs stable. On the out_ready=1 cycle the handshake completes, and in_ready=1 on the following cycle.
- Overflow with MAX_WORDS=4: send 6 beats of 0x01. Required: out_word=0x00, out_count=4, out_overflow=1. The next frame reports out_overflow=0.
- Reset mid-frame: send 2 beats of 0x0F, then pulse rst_n low for part of a cycle, asynchronously between edges. Required: outputs are zero immediately. A subsequent frame of 0x55 with in_last yields out_word=0x55 and out_count=1.
- With XOR_FRAME_CHECK_EN: send a frame of 0x12, 0x34 with in_exp=0x26. Required: out_err=0. Repeat with in_exp=0x27. Required: out_err=1.
